// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Multi-cycle ALU for the accumulator datapath. One operation is accepted per
// valid/ready handshake. Pass/add/sub/logic ops finish on the accept edge.
// SHL shifts one bit per cycle. MUL runs a shift-add multiply, one multiplier
// bit per cycle. The result and its flags are registered, and they change only
// on the edge that enters DONE.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   SHW        number of in_b LSBs used as the shift amount (derived)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operation request
//   in_ready   high only in IDLE; a transfer is in_valid & in_ready on an edge
//   opcode     operation select (see OP_* below)
//   in_a       operand A (accumulator)
//   in_b       operand B (memory)
//   out_valid  one-cycle pulse in the cycle after result/flags update
//   result     registered result
//   is_zero    result == 0
//   carry      carry / borrow / last bit shifted out / multiply overflow
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             is_zero,
  output logic             carry
);

  // The counter holds either a shift amount (< 2**SHW) or WIDTH for MUL.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_PASSB = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  // Architectural state
  logic [1:0]         state_q,  state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q,  carry_d;

  // Working registers for the multi-cycle ops; never visible on the outputs
  logic [WIDTH-1:0]   work_q,   work_d;     // SHL operand being shifted
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;    // MUL multiplicand, shifts left
  logic [WIDTH-1:0]   mplier_q, mplier_d;   // MUL multiplier, shifts right
  logic [2*WIDTH-1:0] acc_q,    acc_d;      // MUL partial product
  logic [CW-1:0]      count_q,  count_d;

  // Single-cycle arithmetic, one bit wider to expose carry/borrow
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] acc_step;
  logic               accept;

  assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
  // Top bit of the extended difference is the borrow: 1 iff A < B unsigned.
  assign diff_ext = {1'b0, in_a} - {1'b0, in_b};
  assign shamt    = in_b[SHW-1:0];
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign accept   = in_valid && (state_q == S_IDLE);

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_PASSA: begin
              result_d = in_a;
              carry_d  = 1'b0;
              state_d  = S_DONE;
            end
            OP_PASSB: begin
              result_d = in_b;
              carry_d  = 1'b0;
              state_d  = S_DONE;
            end
            OP_ADD: begin
              result_d = sum_ext[WIDTH-1:0];
              carry_d  = sum_ext[WIDTH];
              state_d  = S_DONE;
            end
            OP_AND: begin
              result_d = in_a & in_b;
              carry_d  = 1'b0;
              state_d  = S_DONE;
            end
            OP_XOR: begin
              result_d = in_a ^ in_b;
              carry_d  = 1'b0;
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = diff_ext[WIDTH-1:0];
              carry_d  = diff_ext[WIDTH];
              state_d  = S_DONE;
            end
            OP_SHL: begin
              work_d  = in_a;
              count_d = CW'(shamt);
              if (shamt == '0) begin
                // Zero shift: nothing is shifted out, so carry is 0.
                result_d = in_a;
                carry_d  = 1'b0;
                state_d  = S_DONE;
              end else begin
                state_d = S_SHIFT;
              end
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, in_a};
              mplier_d = in_b;
              count_d  = CW'(WIDTH);
              state_d  = S_MUL;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_SHIFT: begin
        work_d  = work_q << 1;
        count_d = count_q - CW'(1);
        // On the last step the bit leaving the MSB is the final carry.
        if (count_q == CW'(1)) begin
          result_d = work_q << 1;
          carry_d  = work_q[WIDTH-1];
          state_d  = S_DONE;
        end
      end

      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        // Last multiplier bit: the product is complete in acc_step.
        if (count_q == CW'(1)) begin
          result_d = acc_step[WIDTH-1:0];
          carry_d  = |acc_step[2*WIDTH-1:WIDTH];
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  // NOTE: the working registers are reset along with the architectural state;
  // it costs little here and keeps them from carrying X into later cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      work_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  // Derived from the result register, so it can never disagree with result.
  assign is_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Bench for alu_seq. An 8-bit and a 16-bit instance share the clock and reset.
// Directed cases come first, then randomized operations. All are checked
// against an arithmetic reference model of the opcode table, including the
// expected latency.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, r8, ov8, z8, c8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  logic        v16, r16, ov16, z16, c16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .opcode(op8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .result(res8), .is_zero(z8),
    .carry(c8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .opcode(op16),
    .in_a(a16), .in_b(b16), .out_valid(ov16), .result(res16), .is_zero(z16),
    .carry(c16)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] prev_res [2];   // last result each instance should be holding

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Reference model: opcode table in plain integer arithmetic.
  function automatic void model(input int w, input int op,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned res, output logic cy,
                                output int lat);
    longint unsigned mask;
    longint unsigned t;
    int shw;
    int n;
    mask = (64'd1 << w) - 64'd1;
    shw  = $clog2(w);
    lat  = 1;
    cy   = 1'b0;
    res  = 0;
    case (op)
      0: res = a;
      1: res = b;
      2: begin t = a + b; res = t & mask; cy = ((t >> w) & 64'd1) != 0; end
      3: res = a & b;
      4: res = a ^ b;
      5: begin res = (a - b) & mask; cy = (a < b); end
      6: begin
        n   = int'(b & ((64'd1 << shw) - 64'd1));
        res = (a << n) & mask;
        cy  = (n != 0) && (((a >> (w - n)) & 64'd1) != 0);
        lat = 1 + n;
      end
      default: begin
        t   = a * b;
        res = t & mask;
        cy  = (t >> w) != 0;
        lat = w + 1;
      end
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      v8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v16 = v; op16 = op; a16 = a; b16 = b;
    end
  endtask

  function automatic logic f_ready(input int w);
    return (w == 8) ? r8 : r16;
  endfunction
  function automatic logic f_valid(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction
  function automatic logic f_zero(input int w);
    return (w == 8) ? z8 : z16;
  endfunction
  function automatic logic f_carry(input int w);
    return (w == 8) ? c8 : c16;
  endfunction
  function automatic logic [15:0] f_result(input int w);
    return (w == 8) ? {8'h00, res8} : res16;
  endfunction

  // Issue one operation from a negedge with the instance idle, then follow it
  // to its out_valid cycle and the following idle cycle. With hold set,
  // in_valid stays high (with scrambled operands) for the whole operation.
  task automatic run(input int w, input logic [2:0] op, input logic [15:0] a_in,
                     input logic [15:0] b_in, input logic hold);
    longint unsigned er;
    logic ec;
    int el;
    int lat;
    int idx;
    logic [15:0] a;
    logic [15:0] b;
    string tag;
    idx = (w == 8) ? 0 : 1;
    a = (w == 8) ? {8'h00, a_in[7:0]} : a_in;
    b = (w == 8) ? {8'h00, b_in[7:0]} : b_in;
    model(w, int'(op), 64'(a), 64'(b), er, ec, el);
    tag = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a, b);

    check({tag, " ready_before"}, 64'(f_ready(w)), 64'd1);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, hold, 3'($urandom), 16'($urandom), 16'($urandom));

    lat = 1;
    while (f_valid(w) !== 1'b1 && lat <= 40) begin
      check({tag, " busy_ready"}, 64'(f_ready(w)), 64'd0);
      check({tag, " busy_result_held"}, 64'(f_result(w)), 64'(prev_res[idx]));
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " result"}, 64'(f_result(w)), 64'(er));
    check({tag, " carry"}, 64'(f_carry(w)), 64'(ec));
    check({tag, " is_zero"}, 64'(f_zero(w)), 64'(er == 0));
    check({tag, " done_ready"}, 64'(f_ready(w)), 64'd0);
    prev_res[idx] = 16'(er);

    @(negedge clk);
    check({tag, " single_pulse"}, 64'(f_valid(w)), 64'd0);
    check({tag, " back_idle"}, 64'(f_ready(w)), 64'd1);
    check({tag, " result_hold"}, 64'(f_result(w)), 64'(er));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    prev_res[0] = '0;
    prev_res[1] = '0;
    drive(8, 1'b0, 3'd0, 16'h0, 16'h0);
    drive(16, 1'b0, 3'd0, 16'h0, 16'h0);

    // Reset state, observed while reset is held
    rst = 1'b1;
    #1;
    check("rst8 result", 64'(res8), 64'd0);
    check("rst8 is_zero", 64'(z8), 64'd1);
    check("rst8 carry", 64'(c8), 64'd0);
    check("rst8 out_valid", 64'(ov8), 64'd0);
    check("rst8 in_ready", 64'(r8), 64'd1);
    check("rst16 result", 64'(res16), 64'd0);
    check("rst16 in_ready", 64'(r16), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed 8-bit cases
    run(8, 3'b010, 16'h00F0, 16'h0020, 1'b0);  // ADD with carry out
    run(8, 3'b101, 16'h0005, 16'h0005, 1'b0);  // SUB to zero
    run(8, 3'b101, 16'h0003, 16'h0005, 1'b0);  // SUB with borrow
    run(8, 3'b110, 16'h0081, 16'h0003, 1'b0);  // SHL by 3
    run(8, 3'b110, 16'h0081, 16'h0001, 1'b0);  // SHL by 1, carry out
    run(8, 3'b110, 16'h0081, 16'h0000, 1'b0);  // SHL by 0
    run(8, 3'b000, 16'h005A, 16'h00A5, 1'b0);  // PASSA
    run(8, 3'b001, 16'h005A, 16'h00A5, 1'b0);  // PASSB
    run(8, 3'b011, 16'h00F3, 16'h003C, 1'b0);  // AND
    run(8, 3'b100, 16'h00F3, 16'h003C, 1'b0);  // XOR
    run(8, 3'b111, 16'h0010, 16'h0011, 1'b1);  // MUL overflow, in_valid held
    run(8, 3'b111, 16'h000F, 16'h000F, 1'b0);  // MUL, no overflow

    // Asynchronous reset in the middle of MUL cycle 4
    drive(8, 1'b1, 3'b111, 16'h00FF, 16'h00FF);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 3'b000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst result", 64'(res8), 64'd0);
    check("midrst is_zero", 64'(z8), 64'd1);
    check("midrst carry", 64'(c8), 64'd0);
    check("midrst in_ready", 64'(r8), 64'd1);
    check("midrst out_valid", 64'(ov8), 64'd0);
    prev_res[0] = '0;
    prev_res[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8 === 1'b1) pulses++;
    end
    check("midrst no_out_valid", 64'(pulses), 64'd0);
    run(8, 3'b010, 16'h0011, 16'h0022, 1'b0);  // ADD after abort

    // Directed 16-bit cases
    run(16, 3'b111, 16'h0100, 16'h0100, 1'b0);
    run(16, 3'b110, 16'h8001, 16'h000F, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      run(8, 3'($urandom), 16'($urandom), 16'($urandom),
          (i != 39) && ($urandom_range(3) == 0));
    for (int i = 0; i < 12; i++)
      run(16, 3'($urandom), 16'($urandom), 16'($urandom),
          (i != 11) && ($urandom_range(3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
